// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues word reads to instruction memory and buffers
// up to two fetched words for the decoder, with redirect support.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4
);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] hold_addr_q, hold_addr_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [31:0] word_q [2];
   logic [31:0] word_d [2];
   logic [31:0] pc_q [2];
   logic [31:0] pc_d [2];

   logic pop;
   logic push;
   logic wr_idx;

   assign instr_valid    = (count_q != 2'd0);
   assign instr          = word_q[rd_ptr_q];
   assign instr_pc       = pc_q[rd_ptr_q];
   assign instr_pc_plus4 = pc_q[rd_ptr_q] + 32'd4;
   assign wr_idx         = rd_ptr_q ^ count_q[0];

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      hold_addr_d = hold_addr_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      word_d      = word_q;
      pc_d        = pc_q;

      unique case (state_q)
         StIdle:  imem_req = !rst && (count_q < 2'd2);
         default: imem_req = !rst;
      endcase
      imem_addr = (state_q == StIdle) ? fetch_pc_q : hold_addr_q;

      pop  = instr_valid && instr_ready;
      // A response is kept only if it belongs to the current fetch stream.
      push = imem_req && imem_ack && (state_q != StDrop) && !redirect_valid;

      unique case (state_q)
         StIdle: begin
            if (imem_req && !imem_ack) begin
               hold_addr_d = fetch_pc_q;
               // A redirect while the request is pending makes its response stale.
               state_d     = redirect_valid ? StDrop : StWait;
            end
         end
         StWait: begin
            if (imem_ack) state_d = StIdle;
            else if (redirect_valid) state_d = StDrop;
         end
         StDrop: begin
            if (imem_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (push) begin
         word_d[wr_idx] = imem_rdata;
         pc_d[wr_idx]   = fetch_pc_q;
         fetch_pc_d     = fetch_pc_q + 32'd4;
      end

      if (pop) rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         count_d    = 2'd0;
         rd_ptr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         fetch_pc_q  <= RESET_PC;
         hold_addr_q <= RESET_PC;
         count_q     <= 2'd0;
         rd_ptr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Buffer contents are qualified by count, so they need no reset.
   always_ff @(posedge clk) begin
      word_q <= word_d;
      pc_q   <= pc_d;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have exactly one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 The ports SHALL be as follows, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned read address.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  32  restart address.
- instr_valid  out  1  head instruction available to the decoder.
- instr_ready  in  1  decoder accepts the head instruction.
- instr  out  32  instruction word to the decoder.
- instr_pc  out  32  address of instr.
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.

Function
REQ-003 The block SHALL hold fetch_pc (32 b), a 2-entry FIFO of {word, pc} with count 0..2, a hold_addr register, and the FSM states IDLE, WAIT and DROP.
REQ-004 instr_valid SHALL equal (count != 0); instr, instr_pc and instr_pc_plus4 SHALL be driven combinationally from the FIFO head, and are don't-care when instr_valid=0.
REQ-005 A pop SHALL occur on any cycle with instr_valid && instr_ready, including a redirect cycle.
REQ-006 In IDLE, imem_req SHALL be (count < 2) and imem_addr SHALL be fetch_pc.
- req && ack: accept the response.
- req && !ack: latch hold_addr <= fetch_pc and go to WAIT.
REQ-007 In WAIT, imem_req SHALL be 1 and imem_addr SHALL be hold_addr, held stable until imem_ack.
- ack: accept the response and go to IDLE.
REQ-008 Accepting a response (no redirect that cycle) SHALL push {imem_rdata, fetch_pc} into the FIFO and set fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-009 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-010 A push SHALL never occur at count=2; the request gating in REQ-006 guarantees this.
REQ-011 On redirect_valid the block SHALL, in that cycle:
- set fetch_pc <= {redirect_pc[31:2], 2'b00};
- clear count to 0, overriding any push or pop;
- discard any response acked that cycle.
REQ-012 A redirect in WAIT with imem_ack=0 SHALL move the FSM to DROP.
REQ-013 In DROP, imem_req SHALL be 1 and imem_addr SHALL be hold_addr; the next ack SHALL be discarded (no push, fetch_pc unchanged) and the FSM SHALL return to IDLE.
REQ-014 A redirect in DROP SHALL update fetch_pc (latest redirect wins) and SHALL leave the FSM in DROP.
REQ-015 imem_rdata SHALL be ignored whenever imem_ack=0, and imem_ack SHALL be ignored whenever imem_req=0.
REQ-016 With a zero-wait memory (ack in the request cycle) and instr_ready held at 1, the block SHALL deliver one instruction per cycle.
REQ-017 The first instruction SHALL appear on instr_valid one cycle after its ack.
REQ-018 The first instruction after a redirect SHALL appear no earlier than two cycles after the redirect cycle.

Reset
REQ-019 While rst=1, imem_req SHALL be 0, and on the clock edge fetch_pc SHALL be set to RESET_PC, count to 0 and the FSM to IDLE.
REQ-020 In the cycle after reset, instr_valid SHALL be 0.
REQ-021 Reset SHALL take priority over redirect_valid, imem_ack and instr_ready.
REQ-022 Reset asserted in WAIT or DROP SHALL abandon the request; the instruction memory is reset by the same rst and SHALL NOT ack after it.

Verification
REQ-023 Case 1, reset and stream: RESET_PC=0x100, zero-wait memory, ready=1 -> instr_pc sequence 0x100, 0x104, 0x108 on consecutive cycles, with instr_valid=1 from cycle 2 after reset release.
REQ-024 Case 2, back-pressure: ready=0 for 5 cycles -> count saturates at 2, imem_req=0, imem_addr unchanged; on release 0x100, 0x104, 0x108 arrive in order with no loss or duplication.
REQ-025 Case 3, wait states: ack 3 cycles late -> imem_addr held constant at the requested address across all wait cycles; the word is pushed with the matching pc.
REQ-026 Case 4, redirect in WAIT: redirect_pc=0x203 while waiting -> FSM enters DROP; the late ack is discarded; the next request address is 0x200; the first delivered instr_pc is 0x200.
REQ-027 Case 5, redirect with simultaneous ack and pop -> FIFO emptied, acked word dropped, instr_valid=0 in the next cycle.
REQ-028 Case 6, wrap-around: redirect to 0xFFFF_FFFC -> instr_pc sequence 0xFFFF_FFFC, 0x0000_0000; instr_pc_plus4 = 0x0000_0000 for the first instruction.
